// File: rtl/logic_unit_acc.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshakes and an ACC_LEN-beat accumulate mode.
// Optional registered zero flag on F: define LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_acc #(
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_val;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             f_load;
    logic [WIDTH-1:0] f_next;
    logic [WIDTH-1:0] res_direct;
    logic [WIDTH-1:0] res_accum;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] sel,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (sel)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x & y);
            3'b100:  return ~(x | y);
            3'b101:  return ~(x ^ y);
            3'b110:  return x & ~y;
            default: return ~x;
        endcase
    endfunction

    // A pending result only blocks the source while the sink is stalling it.
    assign in_ready  = rst_n & ((state != HOLD) | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);

    assign res_direct = apply_op(op, a, b);
    assign res_accum  = apply_op(op_q, acc_val, a);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        f_load = 1'b0;
        f_next = f;
        if (accept) begin
            if (state != ACCUM) begin
                if (!acc) begin
                    f_load = 1'b1;
                    f_next = res_direct;
                end else if (ACC_LEN == 1) begin
                    f_load = 1'b1;
                    f_next = a;
                end
            end else if (cnt == LAST_CNT) begin
                f_load = 1'b1;
                f_next = res_accum;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 3'b000;
            acc_val <= '0;
            cnt     <= '0;
            f       <= '0;
        end else begin
            if (f_load) f <= f_next;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        op_q <= op;
                        if (!acc) begin
                            state <= HOLD;
                        end else begin
                            acc_val <= a;
                            cnt     <= CNT_W'(1);
                            state   <= (ACC_LEN == 1) ? HOLD : ACCUM;
                        end
                    end else if (state == HOLD && out_ready) begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST_CNT) begin
                            acc_val <= '0;
                            cnt     <= '0;
                            state   <= HOLD;
                        end else begin
                            acc_val <= res_accum;
                            cnt     <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    // Zero tracks F exactly: it moves only on the same edge F loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (f_load) begin
            zero <= (f_next == '0);
        end
    end
`else
    assign zero = 1'b0;
`endif

endmodule

// File: doc/logic_unit_acc.md
# logic_unit_acc

Parametrised, registered two-operand bitwise logic unit with a valid/ready handshake on both sides and a multi-beat accumulate mode. It generalises the single-bit combinational gates of the lab library to a WIDTH-bit datapath with eight selectable operations. It sits between a source and a sink that both use valid/ready flow control.

## Interface
- WIDTH, 8: operand/result width in bits (≥1).
- ACC_LEN, 4: beats per accumulate transaction (≥1).
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- In_valid  in  1  source presents a beat.
- In_ready  out  1  unit accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B (ignored in accumulate mode).
- Op  in  3  operation select, sampled on the first beat of a transaction.
- Acc  in  1  0 = direct, 1 = accumulate; sampled on the first beat.
- Out_valid  out  1  F holds a result.
- Out_ready  in  1  sink takes the result.
- F  out  WIDTH  registered result.
- Zero  out  1  registered flag, F == 0 (see Configuration).

## Operation
- Beat accepted: In_valid & In_ready on a rising edge.
- Result transfer: Out_valid & Out_ready on a rising edge.
- In_ready = (state != HOLD) | Out_ready. Combinational from state and Out_ready only; never from In_valid.
- op(X,Y) by Op: 000 X&Y, 001 X|Y, 010 X^Y, 011 ~(X&Y), 100 ~(X|Y), 101 ~(X^Y), 110 X&~Y, 111 ~X.
- Direct mode: X=A, Y=B.
- Accumulate mode: X=acc, Y=A.
- All results are WIDTH bits, bitwise, with no carries.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, or HOLD with Out_ready, when a beat is accepted:
  - Op and Acc are latched.
  - Acc=0: F <= op(A,B); next state HOLD.
  - Acc=1: acc <= A and cnt <= 1. Next state is ACCUM if ACC_LEN > 1. If ACC_LEN = 1, F <= A and next state is HOLD.
- ACCUM, beat accepted:
  - acc <= op(acc, A) using the latched Op; cnt <= cnt+1.
  - When cnt+1 == ACC_LEN: F <= op(acc, A), acc and cnt clear, next state HOLD.
  - Changes on the Op/Acc pins are ignored while in ACCUM.
- HOLD:
  - Out_valid=1; F and Zero stay stable until transfer.
  - Transfer with no new beat accepted: next state IDLE, Out_valid drops.
  - Transfer with a new beat accepted in the same cycle: the new beat is processed as from IDLE, with no bubble.
- In IDLE/ACCUM, Out_valid=0 and F keeps its last value.
- cnt is clog2(ACC_LEN+1) bits and never exceeds ACC_LEN.

## Timing
- Reset (Rst_n low, asynchronous):
  - state=IDLE; F=0, Zero=0, Out_valid=0; acc=0, cnt=0.
  - In_ready forced 0 while Rst_n is low.
- Reset deassertion takes effect at the next Clk edge.
- Reset mid-transaction discards the partial accumulate; no output is produced for it.
- Direct latency: result valid 1 cycle after acceptance.
- Throughput: 1 beat/cycle when Out_ready is held 1.
- Accumulate latency: result valid 1 cycle after the ACC_LEN-th acceptance. Minimum ACC_LEN cycles per transaction.
- With Out_ready=0 in HOLD: In_ready=0 and no beat is accepted. The source must hold its beat.
- The unit has no internal buffering beyond F/acc.

## Configuration
- Macro LOGIC_UNIT_ZERO_FLAG_EN.
- Defined: Zero is registered with F (Zero <= (next F == 0)) and changes only when F loads. It resets to 0.
- Undefined: Zero is tied to 0 and no comparator is built.

## Test plan
- Parameters for all scenarios: WIDTH=8, ACC_LEN=4.
- Op sweep, direct mode: A=F0, B=CC, Op 000..111 back-to-back, Out_ready=1. F must be C0, FC, 3C, 3F, 03, C3, 30, 0F on 8 consecutive cycles, each 1 cycle after its beat.
- Accumulate OR: Acc=1, Op=001, A=01,02,04,08, with Op changed to 000 after beat 1. F=0F and Out_valid=1 exactly 1 cycle after beat 4; Out_valid=0 before that.
- Accumulate XOR with flag: macro defined, Op=010, A=FF,0F,F0,00. F=00, Zero=1. Next, a direct beat A=01, B=00, Op=001 gives F=01, Zero=0.
- Backpressure:
  - Direct result pending with Out_ready=0 for 3 cycles: F stable, Out_valid=1, In_ready=0, and a held In_valid beat is not accepted.
  - Then Out_ready=1: transfer and acceptance happen in the same cycle; the new F appears on the next cycle.
- Reset mid-accumulate:
  - Rst_n pulsed low after 2 of 4 beats (A=11,22, Op=001): F=00, Out_valid=0, In_ready=0 immediately while Rst_n is low.
  - After release, A=01,02,04,08 with Op=001 gives F=0F, with no contribution from 11/22.
